// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants (transmitter + receiver)  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
   localparam int UART_BAUD_TICKS = 28781;
   localparam int UART_BIT_IDX_W  = $clog2(UART_DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_gen : bit-period counter, one-cycle tick on terminal count |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int TICKS = UART_BAUD_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : 8N1 transmitter with one-byte holding register             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_TICKS = UART_BAUD_TICKS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] data,
   input  logic                      valid,
   output logic                      ready,
   output logic                      tx,
   output logic                      busy
);

   localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

   uart_tx_state_t              state_q, state_d;
   logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
   logic [UART_BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0]   hold_q, hold_d;
   logic                        hold_full_q, hold_full_d;
   logic                        tx_q, tx_d;

   logic tick;
   logic accept;
   logic shifter_free;

   uart_baud_gen #(
      .TICKS (BAUD_TICKS)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == IDLE),
      .enable (state_q != IDLE),
      .tick   (tick)
   );

   assign ready        = !hold_full_q;
   assign accept       = valid && ready;
   assign shifter_free = (state_q == IDLE) || ((state_q == STOP) && tick);

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = 1'b1;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = data;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + UART_BIT_IDX_W'(1);
               end
            end
         end
         STOP: begin
            // A held byte has priority; ready is low then, so no acceptance can collide.
            if (tick) begin
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  state_d     = START;
               end else if (accept) begin
                  shift_d = data;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept && !shifter_free) begin
         hold_d      = data;
         hold_full_d = 1'b1;
      end

      // The line is registered from the next state so each level lines up with its slot.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE) || hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx : directed and randomized checks of uart_tx vs line model |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_tx;

   localparam int TA = 4;
   localparam int TB = 16;
   localparam int LB_N = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset = 1'b1, a_valid = 1'b0, a_ready, a_tx, a_busy;
   logic [7:0] a_data  = 8'h00;
   logic       b_reset = 1'b1, b_valid = 1'b0, b_ready, b_tx, b_busy;
   logic [7:0] b_data  = 8'h00;

   uart_tx #(.BAUD_TICKS(TA)) u_a (
      .clk(clk), .reset(a_reset), .data(a_data), .valid(a_valid),
      .ready(a_ready), .tx(a_tx), .busy(a_busy)
   );

   uart_tx #(.BAUD_TICKS(TB)) u_b (
      .clk(clk), .reset(b_reset), .data(b_data), .valid(b_valid),
      .ready(b_ready), .tx(b_tx), .busy(b_busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line level of an 8N1 frame in bit slot 0..9.
   function automatic logic frame_bit(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      if (slot >= 9) return 1'b1;
      return b[slot-1];
   endfunction

   // Stream driver for instance A: captures the line from the cycle after the first acceptance.
   logic [7:0] tx_bytes[$];
   int         acc_at[$];
   logic       cap_tx[$];
   logic       cap_rdy[$];
   logic       cap_busy[$];

   task automatic drive_a(input int ncyc);
      int   i = 0;
      int   n = 0;
      int   guard = 0;
      bit   started = 0;
      logic rp;
      acc_at.delete(); cap_tx.delete(); cap_rdy.delete(); cap_busy.delete();
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = tx_bytes[0];
      rp      = a_ready;
      while (n < ncyc && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (a_valid && rp) begin
            started = 1;
            acc_at.push_back(n);
            i++;
            if (i < tx_bytes.size()) a_data = tx_bytes[i];
            else begin a_valid = 1'b0; a_data = 8'h00; end
         end
         if (started) begin
            cap_tx.push_back(a_tx);
            cap_rdy.push_back(a_ready);
            cap_busy.push_back(a_busy);
            n++;
         end
         rp = a_ready;
      end
      chk("drive_len", n, ncyc);
   endtask

   task automatic check_frames(input string tag);
      for (int f = 0; f < tx_bytes.size(); f++) begin
         int mism = 0;
         for (int c = 0; c < 10*TA; c++) begin
            int k = f*10*TA + c;
            if (k >= cap_tx.size() || cap_tx[k] !== frame_bit(tx_bytes[f], c / TA)) mism++;
         end
         chk($sformatf("%s_frame%0d", tag, f), mism, 0);
      end
   endtask

   // Behavioural receiver on instance B: mid-bit sampling, gap and stop-bit bookkeeping.
   int         cyc = 0;
   logic [7:0] rx_q[$];
   int         rx_stop_bad = 0;
   int         rx_gap_bad  = 0;
   int         last_start  = -1;
   logic [7:0] rx_b;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(negedge clk);
         if (!b_reset && b_tx === 1'b0) begin
            if (last_start >= 0 && (cyc - last_start) != 10*TB) rx_gap_bad++;
            last_start = cyc;
            repeat (TB/2) @(negedge clk);
            if (b_tx !== 1'b0) rx_stop_bad++;
            for (int k = 0; k < 8; k++) begin
               repeat (TB) @(negedge clk);
               rx_b[k] = b_tx;
            end
            repeat (TB) @(negedge clk);
            if (b_tx !== 1'b1) rx_stop_bad++;
            rx_q.push_back(rx_b);
         end
      end
   end

   logic [7:0] lb_bytes[$];

   initial begin
      int idle_bad;
      int mism;
      int guard;
      int i;
      logic rp;

      // Reset held for 3 cycles, then 100 idle cycles.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rst_tx%0d", k), a_tx, 1'b1);
         chk($sformatf("rst_ready%0d", k), a_ready, 1'b1);
         chk($sformatf("rst_busy%0d", k), a_busy, 1'b0);
      end
      a_reset = 1'b0;
      b_reset = 1'b0;
      @(negedge clk);
      chk("rel_tx", a_tx, 1'b1);
      chk("rel_ready", a_ready, 1'b1);
      chk("rel_busy", a_busy, 1'b0);
      idle_bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (a_tx !== 1'b1 || b_tx !== 1'b1) idle_bad++;
      end
      chk("idle_high", idle_bad, 0);

      // Single byte 0xA5.
      tx_bytes = '{8'hA5};
      drive_a(45);
      check_frames("a5");
      chk("a5_busy39", cap_busy[39], 1'b1);
      chk("a5_busy40", cap_busy[40], 1'b0);
      chk("a5_tx40", cap_tx[40], 1'b1);

      // Back-to-back 0x00, 0xFF, 0x3C with valid held.
      tx_bytes = '{8'h00, 8'hFF, 8'h3C};
      drive_a(125);
      chk("b2b_nacc", acc_at.size(), 3);
      chk("b2b_acc1", (acc_at.size() > 1) ? acc_at[1] : -1, 1);
      chk("b2b_acc2", (acc_at.size() > 2) ? acc_at[2] : -1, 41);
      chk("b2b_rdy1", cap_rdy[1], 1'b0);
      chk("b2b_rdy39", cap_rdy[39], 1'b0);
      chk("b2b_rdy40", cap_rdy[40], 1'b1);
      check_frames("b2b");
      idle_bad = 0;
      for (int k = 120; k < 125; k++) if (cap_tx[k] !== 1'b1) idle_bad++;
      chk("b2b_tail", idle_bad, 0);
      chk("b2b_busy120", cap_busy[120], 1'b0);

      // Acceptance on the last STOP cycle goes straight to the shifter.
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = 8'h11;
      @(negedge clk);
      a_valid = 1'b0;
      chk("ls_start0", a_tx, 1'b0);
      repeat (39) @(negedge clk);
      chk("ls_stop_tx", a_tx, 1'b1);
      chk("ls_stop_ready", a_ready, 1'b1);
      a_valid = 1'b1;
      a_data  = 8'h81;
      mism = 0;
      idle_bad = 0;
      for (int c = 0; c < 10*TA; c++) begin
         @(negedge clk);
         if (c == 0) begin
            a_valid = 1'b0;
            chk("ls_next_start", a_tx, 1'b0);
         end
         if (a_tx !== frame_bit(8'h81, c / TA)) mism++;
         if (a_ready !== 1'b1) idle_bad++;
      end
      chk("ls_frame81", mism, 0);
      chk("ls_hold_empty", idle_bad, 0);

      // Randomized back-to-back bytes.
      tx_bytes.delete();
      for (int k = 0; k < 4; k++) tx_bytes.push_back(8'($urandom));
      drive_a(165);
      check_frames("rnd");
      chk("rnd_tail", cap_tx[163], 1'b1);

      // Reset during DATA bit 3 with a byte held.
      tx_bytes = '{8'h33, 8'h44};
      drive_a(18);
      chk("mid_tx_bit3", cap_tx[17], frame_bit(8'h33, 4));
      chk("mid_held", cap_rdy[17], 1'b0);
      a_reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx", a_tx, 1'b1);
      chk("mid_rst_ready", a_ready, 1'b1);
      chk("mid_rst_busy", a_busy, 1'b0);
      a_reset = 1'b0;
      tx_bytes = '{8'h5A};
      drive_a(60);
      check_frames("post_rst");
      idle_bad = 0;
      for (int k = 40; k < 60; k++) if (cap_tx[k] !== 1'b1 || cap_busy[k] !== 1'b0) idle_bad++;
      chk("post_rst_no_stale", idle_bad, 0);

      // Loopback: random bytes back-to-back into the behavioural receiver.
      for (int k = 0; k < LB_N; k++) lb_bytes.push_back(8'($urandom_range(0, 255)));
      @(negedge clk);
      b_valid = 1'b1;
      b_data  = lb_bytes[0];
      rp      = b_ready;
      i       = 0;
      guard   = 0;
      while (i < LB_N && guard < LB_N*10*TB + 1000) begin
         @(negedge clk);
         guard++;
         if (b_valid && rp) begin
            i++;
            if (i < LB_N) b_data = lb_bytes[i];
            else begin b_valid = 1'b0; b_data = 8'h00; end
         end
         rp = b_ready;
      end
      chk("lb_all_accepted", i, LB_N);
      guard = 0;
      while (rx_q.size() < LB_N && guard < 40*TB) begin
         @(negedge clk);
         guard++;
      end
      repeat (2*TB) @(negedge clk);
      chk("lb_count", rx_q.size(), LB_N);
      mism = 0;
      for (int k = 0; k < LB_N; k++) begin
         if (k >= rx_q.size() || rx_q[k] !== lb_bytes[k]) mism++;
      end
      chk("lb_data", mism, 0);
      chk("lb_gap", rx_gap_bad, 0);
      chk("lb_stop", rx_stop_bad, 0);
      chk("lb_busy_end", b_busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
